mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Time-shares one combinational radix-4 Booth multiplier among NREQ requesters.
- Arbitrates round-robin, registers the winner's operands and drives them onto the multiplier inputs.
- Waits a fixed settle time, then captures the product and returns it on a single response port tagged with the requester ID.
- Sits between the processing units and the single multiplier instance in the datapath.

Parameters:
- WIDTH, 12, operand width; must be even (multiplier constraint); product width is 2*WIDTH.
- NREQ, 4, number of requesters; 2..8.
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- SETTLE, 1, cycles the operands are held before the product is sampled; >= 1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- req_valid, input, NREQ, per-requester request valid.
- req_ready, output, NREQ, per-requester accept (one-hot or zero).
- req_x, input, NREQ*WIDTH, signed operand 1; requester i occupies bits [i*WIDTH +: WIDTH].
- req_y, input, NREQ*WIDTH, signed operand 2; same packing as req_x.
- mul_x, output, WIDTH, operand 1 to the shared multiplier.
- mul_y, output, WIDTH, operand 2 to the shared multiplier.
- mul_p, input, 2*WIDTH, product from the shared multiplier.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, consumer accepts the result.
- rsp_id, output, IDW, index of the requester that owns the result.
- rsp_p, output, 2*WIDTH, signed product.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE, rr_ptr=0, cnt=0.
  - op_x=0, op_y=0, so mul_x=mul_y=0.
  - rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, req_ready=0.
  - rst has priority over every other event.
  - Reset mid-operation aborts the operation and discards any pending or presented result; nothing is emitted after reset.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the winner g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready is all zero if no req_valid is set.
  - On the edge with a grant: op_x/op_y <= requester g operand slices; rsp_id <= g; rr_ptr <= (g+1) mod NREQ; cnt <= SETTLE-1; state -> CALC.
  - Requesters must hold req_valid and operands stable until they see req_ready.
- CALC:
  - req_ready=0, mul_x=op_x, mul_y=op_y, busy=1.
  - If cnt==0: rsp_p <= mul_p, rsp_valid <= 1, state -> RESP. Otherwise cnt <= cnt-1.
  - CALC therefore lasts exactly SETTLE cycles.
- RESP:
  - rsp_valid=1; rsp_p and rsp_id are stable; operands are held.
  - On an edge with rsp_ready=1: rsp_valid <= 0, state -> IDLE.
  - No new grant is issued in the same cycle.
- Latency:
  - rsp_valid rises SETTLE edges after the accepting edge.
  - Minimum issue interval is SETTLE+2 cycles, with rsp_ready tied high.
- Arithmetic:
  - The block performs no arithmetic on data.
  - rsp_p is mul_p bit-exact, 2*WIDTH bits, two's complement.
- Fairness:
  - The requester just served has the lowest priority next round.
  - No requester with req_valid held high waits more than NREQ-1 grants.
- Simultaneous events:
  - A req_valid that rises while the FSM is in CALC or RESP waits; it is never dropped.
  - rsp_ready high while rsp_valid=0 has no effect.
  - A req_valid bit for an index >= NREQ cannot exist; no ID outside 0..NREQ-1 is ever produced.
- rr_ptr wraps from NREQ-1 to 0.
- busy is registered state decode (0 in IDLE, 1 otherwise).

Test Plan:
- Reset then idle: rst held 2 cycles, all req_valid=0 -> req_ready=0, rsp_valid=0, busy=0, mul_x=mul_y=0 every cycle.
- Single request: req 1 with x=12'hFFD (-3), y=12'h005, SETTLE=1, bench multiplier model attached -> req_ready=4'b0010 for 1 cycle; rsp_valid 1 edge later; rsp_id=1; rsp_p=24'hFFFFF1 (-15).
- Round-robin: all 4 req_valid held high, rsp_ready=1, x=i+1, y=2 -> grants in order 0,1,2,3,0; products 2,4,6,8,2; issue interval 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_p/rsp_id held constant, req_ready stays 0 despite pending req_valid; rsp_ready=1 -> next grant goes to the next requester after IDLE.
- Extremes with SETTLE=3: x=12'h800 (-2048), y=12'h800 -> CALC lasts 3 cycles; rsp_p=24'h400000 (4194304). Then x=12'h7FF, y=12'h800 -> rsp_p=24'hC00800.
- Reset mid-operation: assert rst during CALC, then during RESP -> next cycle rsp_valid=0, busy=0, rr_ptr=0; a subsequent request from requester 2 alone is granted with rsp_id=2.

Source files
------------

// File: rtl/mult_share_if.sv
// Request/multiplier/response bundle between the processing units, the shared
// multiplier and mult_share_ctrl.
interface mult_share_if #(
  parameter int WIDTH = 12,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [WIDTH-1:0]      mul_x;
  logic [WIDTH-1:0]      mul_y;
  logic [2*WIDTH-1:0]    mul_p;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_p;
  logic                  busy;

  modport slave (
    input  req_valid, req_x, req_y, mul_p, rsp_ready,
    output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output req_valid, req_x, req_y, mul_p, rsp_ready,
    input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin time-sharing controller for one combinational Booth multiplier.
// state | meaning
// IDLE  | arbitrating; req_ready shows the winner
// CALC  | operands held on mul_x/mul_y for SETTLE cycles
// RESP  | product presented on rsp_*, waiting for rsp_ready
module mult_share_ctrl #(
  parameter int WIDTH  = 12,
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  mult_share_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_x_q, op_x_d;
  logic [WIDTH-1:0] op_y_q, op_y_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [PW-1:0]    rsp_p_q, rsp_p_d;
  logic             busy_q, busy_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;
  logic [NREQ-1:0]  req_ready;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (bus.req_valid[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld && !rst) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          op_x_d   = bus.req_x[int'(grant_idx)*WIDTH +: WIDTH];
          op_y_d   = bus.req_y[int'(grant_idx)*WIDTH +: WIDTH];
          rsp_id_d = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d    = CW'(SETTLE - 1);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          rsp_p_d     = bus.mul_p;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mul_x     = op_x_q;
  assign bus.mul_y     = op_y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: one instance with SETTLE=1, one with SETTLE=3,
// each driving a behavioural signed multiplier.
module tb_mult_share_ctrl;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mult_share_if #(.WIDTH(12), .NREQ(4), .IDW(2)) if1 ();
  mult_share_if #(.WIDTH(12), .NREQ(4), .IDW(2)) if3 ();

  mult_share_ctrl #(.WIDTH(12), .NREQ(4), .IDW(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1)
  );
  mult_share_ctrl #(.WIDTH(12), .NREQ(4), .IDW(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(if3)
  );

  assign if1.mul_p = $signed(if1.mul_x) * $signed(if1.mul_y);
  assign if3.mul_p = $signed(if3.mul_x) * $signed(if3.mul_y);

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [23:0] exp_p;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk1(input string tag);
    chk({tag, " req_ready"}, 32'(if1.req_ready), 32'h0);
    chk({tag, " rsp_valid"}, 32'(if1.rsp_valid), 32'h0);
    chk({tag, " busy"}, 32'(if1.busy), 32'h0);
    chk({tag, " mul_x"}, 32'(if1.mul_x), 32'h0);
    chk({tag, " mul_y"}, 32'(if1.mul_y), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Search starts at rr_ptr; comments give the pointer before each vector.
    vecs[0] = '{4'b0010, 12'hFFD, 12'h005, 4'b0010, 2'd1, 24'hFFFFF1}; // rr 0
    vecs[1] = '{4'b0011, 12'h003, 12'h004, 4'b0001, 2'd0, 24'h00000C}; // rr 2
    vecs[2] = '{4'b1001, 12'h7FF, 12'h7FF, 4'b1000, 2'd3, 24'h3FF001}; // rr 1
    vecs[3] = '{4'b1000, 12'h800, 12'h001, 4'b1000, 2'd3, 24'hFFF800}; // rr 0
    vecs[4] = '{4'b0100, 12'h010, 12'hFF0, 4'b0100, 2'd2, 24'hFFFF00}; // rr 0
    vecs[5] = '{4'b0111, 12'h000, 12'h123, 4'b0001, 2'd0, 24'h000000}; // rr 3

    rst1 = 1'b1; rst3 = 1'b1;
    if1.req_valid = '0; if1.req_x = '0; if1.req_y = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = '0; if3.req_x = '0; if3.req_y = '0; if3.rsp_ready = 1'b0;

    tick(); idle_chk1("rst c1");
    tick(); idle_chk1("rst c2");
    rst1 = 1'b0;
    tick(); idle_chk1("idle");

    // Table-driven single transactions, rsp_ready held high.
    if1.rsp_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        if1.req_x[i*12 +: 12] = 12'h555;
        if1.req_y[i*12 +: 12] = 12'h2AA;
      end
      if1.req_x[int'(vecs[v].exp_id)*12 +: 12] = vecs[v].x;
      if1.req_y[int'(vecs[v].exp_id)*12 +: 12] = vecs[v].y;
      if1.req_valid = vecs[v].valid;
      #1;
      chk($sformatf("vec%0d req_ready", v), 32'(if1.req_ready), 32'(vecs[v].exp_ready));
      tick();
      if1.req_valid = '0;
      #1;
      chk($sformatf("vec%0d calc busy", v), 32'(if1.busy), 32'h1);
      chk($sformatf("vec%0d calc ready", v), 32'(if1.req_ready), 32'h0);
      chk($sformatf("vec%0d mul_x", v), 32'(if1.mul_x), 32'(vecs[v].x));
      chk($sformatf("vec%0d mul_y", v), 32'(if1.mul_y), 32'(vecs[v].y));
      chk($sformatf("vec%0d early rsp", v), 32'(if1.rsp_valid), 32'h0);
      tick();
      chk($sformatf("vec%0d rsp_valid", v), 32'(if1.rsp_valid), 32'h1);
      chk($sformatf("vec%0d rsp_id", v), 32'(if1.rsp_id), 32'(vecs[v].exp_id));
      chk($sformatf("vec%0d rsp_p", v), 32'(if1.rsp_p), 32'(vecs[v].exp_p));
      tick();
      chk($sformatf("vec%0d done valid", v), 32'(if1.rsp_valid), 32'h0);
      chk($sformatf("vec%0d done busy", v), 32'(if1.busy), 32'h0);
    end

    // Round robin with all requesters held high from a fresh reset.
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if1.req_x[i*12 +: 12] = 12'(i + 1);
      if1.req_y[i*12 +: 12] = 12'h002;
    end
    if1.req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("rr%0d grant", n), 32'(if1.req_ready), 32'(1 << (n % 4)));
      tick();
      chk($sformatf("rr%0d calc ready", n), 32'(if1.req_ready), 32'h0);
      tick();
      chk($sformatf("rr%0d rsp_valid", n), 32'(if1.rsp_valid), 32'h1);
      chk($sformatf("rr%0d rsp_id", n), 32'(if1.rsp_id), 32'(n % 4));
      chk($sformatf("rr%0d rsp_p", n), 32'(if1.rsp_p), 32'(2 * ((n % 4) + 1)));
      chk($sformatf("rr%0d resp ready", n), 32'(if1.req_ready), 32'h0);
      tick();
    end

    // Backpressure: result must hold while requests keep pending.
    if1.rsp_ready = 1'b0;
    #1;
    chk("bp grant", 32'(if1.req_ready), 32'b0010);
    tick(); tick();
    chk("bp rsp_valid", 32'(if1.rsp_valid), 32'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp%0d rsp_valid", c), 32'(if1.rsp_valid), 32'h1);
      chk($sformatf("bp%0d rsp_id", c), 32'(if1.rsp_id), 32'h1);
      chk($sformatf("bp%0d rsp_p", c), 32'(if1.rsp_p), 32'h4);
      chk($sformatf("bp%0d req_ready", c), 32'(if1.req_ready), 32'h0);
    end
    if1.rsp_ready = 1'b1;
    tick();
    chk("bp next grant", 32'(if1.req_ready), 32'b0100);
    chk("bp released", 32'(if1.rsp_valid), 32'h0);
    if1.req_valid = '0;
    tick();
    chk("bp no grant busy", 32'(if1.busy), 32'h0);

    // Reset during CALC: rr_ptr must return to 0.
    if1.req_x[12 +: 12] = 12'h002; if1.req_y[12 +: 12] = 12'h003;
    if1.req_valid = 4'b0010;
    tick();
    chk("rstc in calc", 32'(if1.busy), 32'h1);
    rst1 = 1'b1; if1.req_valid = '0;
    tick();
    rst1 = 1'b0;
    chk("rstc rsp_valid", 32'(if1.rsp_valid), 32'h0);
    chk("rstc busy", 32'(if1.busy), 32'h0);
    chk("rstc mul_x", 32'(if1.mul_x), 32'h0);
    if1.req_valid = 4'b0110;
    #1;
    chk("rstc rr_ptr 0", 32'(if1.req_ready), 32'b0010);
    tick();
    if1.req_valid = '0; if1.rsp_ready = 1'b0;
    tick();
    chk("rstr in resp", 32'(if1.rsp_valid), 32'h1);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("rstr rsp_valid", 32'(if1.rsp_valid), 32'h0);
    chk("rstr busy", 32'(if1.busy), 32'h0);
    chk("rstr rsp_id", 32'(if1.rsp_id), 32'h0);
    chk("rstr rsp_p", 32'(if1.rsp_p), 32'h0);
    tick();
    chk("rstr nothing emitted", 32'(if1.rsp_valid), 32'h0);
    if1.req_x[24 +: 12] = 12'h002; if1.req_y[24 +: 12] = 12'h003;
    if1.req_valid = 4'b0100;
    #1;
    chk("post rst grant", 32'(if1.req_ready), 32'b0100);
    tick();
    if1.req_valid = '0;
    tick();
    chk("post rst rsp_valid", 32'(if1.rsp_valid), 32'h1);
    chk("post rst rsp_id", 32'(if1.rsp_id), 32'h2);
    chk("post rst rsp_p", 32'(if1.rsp_p), 32'h6);
    if1.rsp_ready = 1'b1;
    tick();

    // SETTLE=3 extremes.
    rst3 = 1'b0;
    if3.rsp_ready = 1'b1;
    if3.req_x[0 +: 12] = 12'h800; if3.req_y[0 +: 12] = 12'h800;
    if3.req_valid = 4'b0001;
    #1;
    chk("s3a grant", 32'(if3.req_ready), 32'b0001);
    tick();
    if3.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("s3a calc%0d busy", c), 32'(if3.busy), 32'h1);
      chk($sformatf("s3a calc%0d rsp_valid", c), 32'(if3.rsp_valid), 32'h0);
      tick();
    end
    chk("s3a rsp_valid", 32'(if3.rsp_valid), 32'h1);
    chk("s3a rsp_p", 32'(if3.rsp_p), 32'h400000);
    chk("s3a rsp_id", 32'(if3.rsp_id), 32'h0);
    tick();
    if3.req_x[12 +: 12] = 12'h7FF; if3.req_y[12 +: 12] = 12'h800;
    if3.req_valid = 4'b0010;
    #1;
    chk("s3b grant", 32'(if3.req_ready), 32'b0010);
    tick();
    if3.req_valid = '0;
    tick(); tick();
    chk("s3b early", 32'(if3.rsp_valid), 32'h0);
    tick();
    chk("s3b rsp_valid", 32'(if3.rsp_valid), 32'h1);
    chk("s3b rsp_p", 32'(if3.rsp_p), 32'hC00800);
    chk("s3b rsp_id", 32'(if3.rsp_id), 32'h1);
    tick();
    chk("s3b idle", 32'(if3.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
